ps2_key_decoder: RTL and testbench

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

---
 rtl/ps2_key_decoder.sv | 152 +++++++++++++++
 tb/tb_ps2_key_decoder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: synchronizes and de-glitches the PS/2 lines, frames bytes,
// and folds E0/F0 prefixes into a single toggle-strobed key word.
module ps2_key_decoder #(
   parameter int FILTER  = 8,
   parameter int TIMEOUT = 50000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic [10:0] ps2_key,
   output logic        err
);

   localparam int FW = (FILTER  > 1) ? $clog2(FILTER + 1)  : 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   state_t        state;
   logic [1:0]    clk_sync;
   logic [1:0]    data_sync;
   logic [FW-1:0] filt_cnt;
   logic          clk_filt;
   logic          clk_filt_q;
   logic [2:0]    bit_cnt;
   logic [7:0]    shift;
   logic          parity_ok;
   logic [TW-1:0] tout_cnt;
   logic          byte_rdy;
   logic          ext;
   logic          brk;
   logic          fall;
   logic          sample;
   logic          timeout;
   logic          err_evt;

   assign fall    = clk_filt_q & ~clk_filt;
   assign sample  = data_sync[1];
   assign timeout = (state != IDLE) && (tout_cnt == TW'(TIMEOUT - 1));

   // Synchronizers and the clock filter; lines idle high so everything resets to 1.
   always_ff @(posedge clk) begin
      if (reset) begin
         clk_sync   <= 2'b11;
         data_sync  <= 2'b11;
         filt_cnt   <= '0;
         clk_filt   <= 1'b1;
         clk_filt_q <= 1'b1;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         clk_sync   <= {clk_sync[0], ps2_clk};
         data_sync  <= {data_sync[0], ps2_data};
         clk_filt_q <= clk_filt;
         if (clk_sync[1] == clk_filt) begin
            filt_cnt <= '0;
         end else if (filt_cnt == FW'(FILTER - 1)) begin
            clk_filt <= clk_sync[1];
            filt_cnt <= '0;
         end else begin
            filt_cnt <= filt_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      // NOTE: a default assignment first keeps this combinational block latch-free.
      err_evt = 1'b0;
      if (fall) begin
         if (state == IDLE && sample)
            err_evt = 1'b1;
         else if (state == STOP && !(sample && parity_ok))
            err_evt = 1'b1;
      end else if (timeout) begin
         err_evt = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         shift     <= '0;
         parity_ok <= 1'b0;
         tout_cnt  <= '0;
         byte_rdy  <= 1'b0;
         ext       <= 1'b0;
         brk       <= 1'b0;
         ps2_key   <= '0;
         err       <= 1'b0;
      end else begin
         byte_rdy <= 1'b0;
         err      <= err_evt;

         if (byte_rdy) begin
            case (shift)
               8'hE0:   ext <= 1'b1;
               8'hF0:   brk <= 1'b1;
               default: begin
                  ps2_key <= {~ps2_key[10], ~brk, ext, shift};
                  ext     <= 1'b0;
                  brk     <= 1'b0;
               end
            endcase
         end

         // An edge coinciding with a timeout wins: it is processed and the counter restarts.
         if (fall) begin
            tout_cnt <= '0;
            case (state)
               IDLE: begin
                  if (!sample) begin
                     state   <= DATA;
                     bit_cnt <= '0;
                  end
               end
               DATA: begin
                  shift <= {sample, shift[7:1]};
                  if (bit_cnt == 3'd7)
                     state <= PARITY;
                  else
                     bit_cnt <= bit_cnt + 1'b1;
               end
               PARITY: begin
                  parity_ok <= ^{sample, shift};
                  state     <= STOP;
               end
               STOP: begin
                  state <= IDLE;
                  if (sample && parity_ok)
                     byte_rdy <= 1'b1;
               end
               default: state <= IDLE;
            endcase
         end else if (state == IDLE) begin
            tout_cnt <= '0;
         end else if (timeout) begin
            state    <= IDLE;
            tout_cnt <= '0;
         end else begin
            tout_cnt <= tout_cnt + 1'b1;
         end

         // Errors drop any pending prefix so it cannot attach to the next key.
         if (err_evt) begin
            ext <= 1'b0;
            brk <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Randomized scoreboard bench for ps2_key_decoder: a frame-level model queues expected
// keys and error pulses; a negedge monitor pops and compares them as the DUT reports.
module tb_ps2_key_decoder;

   localparam int FILTER  = 4;
   localparam int TIMEOUT = 200;
   localparam int HALF    = 12;

   typedef struct {
      bit          is_err;
      logic [10:0] key;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ps2_clk = 1'b1;
   logic        ps2_data = 1'b1;
   logic [10:0] ps2_key;
   logic        err;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail = 0;
   bit   m_tog = 1'b0;
   bit   m_ext = 1'b0;
   bit   m_brk = 1'b0;

   ps2_key_decoder #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .ps2_key(ps2_key), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Frame-level reference: what one complete frame should produce.
   task automatic model_err();
      exp_t e;
      e.is_err = 1'b1;
      e.key    = '0;
      exp_q.push_back(e);
      m_ext = 1'b0;
      m_brk = 1'b0;
   endtask

   task automatic model_frame(input logic [7:0] b, input bit bad);
      exp_t e;
      if (bad) begin
         model_err();
      end else if (b == 8'hE0) begin
         m_ext = 1'b1;
      end else if (b == 8'hF0) begin
         m_brk = 1'b1;
      end else begin
         m_tog    = ~m_tog;
         e.is_err = 1'b0;
         e.key    = {m_tog, ~m_brk, m_ext, b};
         exp_q.push_back(e);
         m_ext = 1'b0;
         m_brk = 1'b0;
      end
   endtask

   task automatic send_bit(input logic b, input bit glitch);
      ps2_data = b;
      tick(8);
      if (glitch) begin
         ps2_clk = 1'b0;
         tick(FILTER - 1);
         ps2_clk = 1'b1;
      end
      tick(HALF);
      ps2_clk = 1'b0;
      tick(HALF);
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad, input int glitch_bit, input int nbits);
      logic [10:0] bits;
      bits = {1'b1, (~(^b)) ^ bad, b, 1'b0};
      for (int i = 0; i < nbits; i++)
         send_bit(bits[i], i == glitch_bit);
      ps2_data = 1'b1;
      tick(6);
   endtask

   task automatic frame(input logic [7:0] b, input bit bad, input int glitch_bit);
      model_frame(b, bad);
      send_frame(b, bad, glitch_bit, 11);
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 4000 && exp_q.size() != 0; i++)
         tick(1);
      check("drain", exp_q.size(), 0);
      tick(4);
   endtask

   // Monitor: every key change or err pulse consumes exactly one expectation.
   logic [10:0] prev_key = '0;
   logic        prev_err = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         prev_key = '0;
         prev_err = 1'b0;
      end else begin
         if (ps2_key !== prev_key) begin
            if (exp_q.size() == 0) begin
               check("key_unexpected", ps2_key, prev_key);
            end else begin
               e = exp_q.pop_front();
               check("key_kind", e.is_err, 0);
               check("key_value", ps2_key, e.key);
            end
            prev_key = ps2_key;
         end
         if (err) begin
            check("err_width", prev_err, 0);
            if (exp_q.size() == 0) begin
               check("err_unexpected", err, 0);
            end else begin
               e = exp_q.pop_front();
               check("err_kind", e.is_err, 1);
            end
         end
         prev_err = err;
      end
   end

   initial begin
      logic [7:0] b;
      int         r;
      tick(10);
      check("reset_key", ps2_key, 0);
      check("reset_err", err, 0);
      reset = 1'b0;
      tick(20);

      frame(8'h1C, 0, -1);
      wait_drain();
      check("make_1c", ps2_key, 11'h61C);

      frame(8'hF0, 0, -1);
      frame(8'h1C, 0, -1);
      wait_drain();
      check("break_1c", ps2_key, 11'h01C);

      frame(8'hE0, 0, -1);
      frame(8'h75, 0, -1);
      wait_drain();
      check("ext_make_75", ps2_key, 11'h775);
      frame(8'hE0, 0, -1);
      frame(8'hF0, 0, -1);
      frame(8'h75, 0, -1);
      wait_drain();
      check("ext_break_75", ps2_key, 11'h175);

      frame(8'hE0, 0, -1);
      frame(8'h1C, 1, -1);
      wait_drain();
      check("parity_err_hold", ps2_key, 11'h175);
      frame(8'h1C, 0, -1);
      wait_drain();
      check("after_parity_err", ps2_key, 11'h61C);

      // Stall after start + 4 data bits until the frame times out.
      model_err();
      send_frame(8'h29, 0, -1, 5);
      tick(TIMEOUT + 50);
      wait_drain();
      frame(8'h29, 0, -1);
      wait_drain();
      check("after_timeout", ps2_key, 11'h229);

      // A high start bit is rejected in IDLE.
      model_err();
      send_bit(1'b1, 0);
      tick(6);
      wait_drain();
      check("bad_start_hold", ps2_key, 11'h229);

      frame(8'h5A, 0, 3);
      wait_drain();
      check("glitch_frame", ps2_key, 11'h65A);

      for (int n = 0; n < 40; n++) begin
         r = $urandom_range(0, 9);
         b = 8'($urandom_range(0, 255));
         if (r < 2)       frame(8'hE0, 0, -1);
         else if (r == 2) frame(8'hF0, 0, -1);
         else if (r == 3) frame(b, 1, -1);
         else             frame(b, 0, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 9)) : -1);
         tick($urandom_range(0, 30));
      end
      wait_drain();

      // Reset in the middle of a frame: silent abandon, key cleared.
      send_frame(8'h33, 0, -1, 6);
      reset = 1'b1;
      exp_q.delete();
      m_tog = 1'b0;
      m_ext = 1'b0;
      m_brk = 1'b0;
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      tick(5);
      reset = 1'b0;
      tick(40);
      check("reset_mid_frame", ps2_key, 0);
      frame(8'h1C, 0, -1);
      wait_drain();
      check("first_after_reset", ps2_key, 11'h61C);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
